// File: rtl/mult_hilo_unit.sv
// HI/LO multiply sequencer: issues operand magnitudes to an external unsigned multiplier,
// waits its latency, then sign-corrects, optionally accumulates, and writes HI/LO.
module mult_hilo_unit #(
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_signed,
    input  logic        accumulate,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_r,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic        neg;
    logic        acc;
    logic        accept;
    logic        done;
    logic [63:0] product;
    logic [63:0] result;

    // Two's complement magnitude; 0x80000000 maps onto itself.
    function automatic logic [31:0] magnitude(input logic [31:0] x);
        return x[31] ? (~x + 32'd1) : x;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: defaults are assigned before any branch so no latch is inferred.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy    = (state == WAIT);
    assign product = neg ? (~mul_r + 64'd1) : mul_r;
    assign result  = acc ? ({hi, lo} + product) : product;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= 4'd0;
            mul_a <= 32'd0;
            mul_b <= 32'd0;
            neg   <= 1'b0;
            acc   <= 1'b0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else if (accept) begin
            mul_a <= is_signed ? magnitude(a) : a;
            mul_b <= is_signed ? magnitude(b) : b;
            neg   <= is_signed & (a[31] ^ b[31]);
            acc   <= accumulate;
            cnt   <= 4'(LATENCY);
        end else if (done) begin
            {hi, lo} <= result;
        end else if (state == WAIT) begin
            cnt <= cnt - 4'd1;
        end else begin
            // Idle with no start: register moves from the CPU.
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
        end
    end

endmodule
